avm_sram_wide_controller: RTL and testbench
===========================================

AVM_SRAM_WIDE_CONTROLLER -- requirements
Module: avm_sram_wide_controller

Interface
REQ-001 The block SHALL have parameter AVM_DW, default 32, meaning Avalon data width in bits; it SHALL be an integer multiple R = AVM_DW/SRAM_DW of SRAM_DW.
REQ-002 The block SHALL have parameter SRAM_DW, default 16, meaning SRAM data width in bits (8 or 16); L = SRAM_DW/8 byte lanes.
REQ-003 The block SHALL have parameter SRAM_AW, default 18, meaning SRAM word-address width.
REQ-004 The block SHALL have parameter AVM_AW, default 20, meaning Avalon byte-address width.
REQ-005 The block SHALL have parameter WAIT_CYCLES, default 0, range 0..3, meaning extra SRAM cycles per sub-word access; T = 1+WAIT_CYCLES.
REQ-006 The block SHALL use one clock, clk, and an asynchronous active-low reset, reset_n.
REQ-007 The ports SHALL be:
clk  in  1  clock
reset_n  in  1  async active-low reset
avm_address  in  AVM_AW  byte address
avm_byteenable  in  AVM_DW/8  write byte enables
avm_read  in  1  read request
avm_write  in  1  write request
avm_writedata  in  AVM_DW  write data
avm_waitrequest  out  1  slave busy
avm_readdata  out  AVM_DW  read data
avm_readdatavalid  out  1  read data strobe
sram_addr  out  SRAM_AW  SRAM word address
sram_writedata  out  SRAM_DW  SRAM write data
sram_readdata  in  SRAM_DW  SRAM read data
sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low strobes
sram_be_n  out  L  active-low byte-lane enables

Function
REQ-008 The FSM SHALL have states IDLE, ACCESS, RESP; avm_waitrequest SHALL be 1 exactly when state is not IDLE.
REQ-009 A command SHALL be accepted in IDLE on a cycle with avm_read or avm_write high; if both are high, the write SHALL be performed and the read ignored.
REQ-010 On acceptance, address, byteenable and writedata SHALL be registered; SRAM base word = avm_address[AVM_AW-1:log2(AVM_DW/8)] * R, truncated to SRAM_AW bits (wrap-around).
REQ-011 Sub-word k (0..R-1) SHALL use sram_addr = base+k, writedata bits [k*SRAM_DW +: SRAM_DW], byteenable bits [k*L +: L].
REQ-012 Each performed sub-word SHALL hold sram_ce_n=0, stable sram_addr and sram_be_n for exactly T consecutive cycles, with sub-words performed back-to-back in ascending k.
REQ-013 Write sub-words SHALL drive sram_we_n=0, sram_oe_n=1, sram_be_n = ~lane enables; sub-words with all-zero lane enables SHALL be skipped and consume no cycles.
REQ-014 A write with all-zero avm_byteenable SHALL be accepted with no SRAM strobe and no waitrequest assertion.
REQ-015 Read sub-words SHALL drive sram_oe_n=0, sram_we_n=1, sram_be_n all 0, ignore avm_byteenable, and sample sram_readdata at the last of the T cycles into lane k of avm_readdata.
REQ-016 After the last read sub-word, the FSM SHALL enter RESP for one cycle, asserting avm_readdatavalid=1 with the fully assembled avm_readdata, then return to IDLE.
REQ-017 After the last performed write sub-word, the FSM SHALL return directly to IDLE.
REQ-018 Timing, acceptance at cycle N, no skips: sub-word k occupies cycles N+1+k*T..N+(k+1)*T; a read's readdatavalid occurs at N+R*T+1.
REQ-019 avm_readdata SHALL hold its last value until the next read completes.
REQ-020 In IDLE, and between accesses, all SRAM strobes and sram_be_n SHALL be 1, and sram_addr and sram_writedata SHALL be 0.

Reset
REQ-021 When reset_n=0, the block SHALL immediately enter IDLE; avm_waitrequest=0, avm_readdatavalid=0, avm_readdata=0, all SRAM strobes and sram_be_n=1, sram_addr=0, sram_writedata=0.
REQ-022 Reset during an access SHALL discard that access, with no avm_readdatavalid pulse and no further SRAM strobes.

Verification
REQ-023 With defaults, write 0x4, be 1111, data 0xBBBBAAAA at cycle N -> word 2=0xAAAA at N+1, word 3=0xBBBB at N+2, we_n low one cycle each, waitrequest high N+1..N+2.
REQ-024 Read 0x4 at N -> oe_n low N+1..N+2, readdatavalid=1 at N+3 with 0xBBBBAAAA.
REQ-025 Write 0x20 be 0011 data 0x0000FFFF over 0xDEADBEEF -> only word 0x10 strobed, sram_be_n=00, waitrequest high 1 cycle; readback 0xDEADFFFF.
REQ-026 Write 0x10 be 1000 data 0xFF345678 over 0x12345678 -> sub-word 0 skipped, word 9 strobed with sram_be_n=01; readback 0xFF345678.
REQ-027 With WAIT_CYCLES=2, read at N -> each sub-word holds 3 cycles, readdatavalid at N+7.
REQ-028 Assert reset_n=0 during read sub-word 1 -> strobes high asynchronously, no readdatavalid; after release, a read of 0x4 returns 0xBBBBAAAA.

Source files
------------

// File: rtl/avm_sram_wide_controller.sv
// rtl/avm_sram_wide_controller.sv - Avalon-MM slave that splits wide accesses into narrow async SRAM sub-word cycles
module avm_sram_wide_controller #(
   parameter int AVM_DW      = 32,
   parameter int SRAM_DW     = 16,
   parameter int SRAM_AW     = 18,
   parameter int AVM_AW      = 20,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [AVM_AW-1:0]    avm_address,
   input  logic [AVM_DW/8-1:0]  avm_byteenable,
   input  logic                 avm_read,
   input  logic                 avm_write,
   input  logic [AVM_DW-1:0]    avm_writedata,
   output logic                 avm_waitrequest,
   output logic [AVM_DW-1:0]    avm_readdata,
   output logic                 avm_readdatavalid,
   output logic [SRAM_AW-1:0]   sram_addr,
   output logic [SRAM_DW-1:0]   sram_writedata,
   input  logic [SRAM_DW-1:0]   sram_readdata,
   output logic                 sram_ce_n,
   output logic                 sram_oe_n,
   output logic                 sram_we_n,
   output logic [SRAM_DW/8-1:0] sram_be_n
);

   localparam int R   = AVM_DW / SRAM_DW;
   localparam int L   = SRAM_DW / 8;
   localparam int BEW = AVM_DW / 8;
   localparam int BSH = $clog2(BEW);
   localparam int KW  = (R > 1) ? $clog2(R) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   localparam logic [1:0]         LAST_CNT = 2'(WAIT_CYCLES);
   localparam logic [SRAM_AW-1:0] R_W      = SRAM_AW'(R);

   logic [1:0]         state_q, state_d;
   logic [KW-1:0]      k_q, k_d;
   logic [1:0]         cnt_q, cnt_d;
   logic               wr_q, wr_d;
   logic [SRAM_AW-1:0] base_q, base_d;
   logic [BEW-1:0]     be_q, be_d;
   logic [AVM_DW-1:0]  wdata_q, wdata_d;
   logic [AVM_DW-1:0]  buf_q, buf_d;
   logic [AVM_DW-1:0]  rdata_q, rdata_d;

   logic [SRAM_AW-1:0] word_idx;
   logic [SRAM_AW-1:0] base_acc;
   logic               first_found;
   logic [KW-1:0]      first_k;
   logic               nxt_found;
   logic [KW-1:0]      nxt_k;

   // Wide word index scaled to SRAM words; truncation to SRAM_AW gives the wrap-around.
   assign word_idx = SRAM_AW'(avm_address >> BSH);
   assign base_acc = word_idx * R_W;

   // Lowest sub-word of an incoming write that has any lane enabled.
   always_comb begin
      first_found = 1'b0;
      first_k     = '0;
      for (int i = R - 1; i >= 0; i--) begin
         if (|avm_byteenable[i*L +: L]) begin
            first_found = 1'b1;
            first_k     = KW'(i);
         end
      end
   end

   // Next sub-word after the current one; reads take every sub-word, writes skip empty ones.
   always_comb begin
      nxt_found = 1'b0;
      nxt_k     = '0;
      for (int i = R - 1; i >= 0; i--) begin
         if ((KW'(i) > k_q) && (!wr_q || (|be_q[i*L +: L]))) begin
            nxt_found = 1'b1;
            nxt_k     = KW'(i);
         end
      end
   end

   // Command acceptance, sub-word sequencing and read-data assembly.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      base_d  = base_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      buf_d   = buf_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (avm_write || avm_read) begin
               wr_d    = avm_write;
               base_d  = base_acc;
               be_d    = avm_byteenable;
               wdata_d = avm_writedata;
               cnt_d   = '0;
               if (avm_write) begin
                  k_d = first_k;
                  // A write with no lanes enabled completes without touching the SRAM.
                  if (first_found) state_d = S_ACCESS;
               end else begin
                  k_d     = '0;
                  state_d = S_ACCESS;
               end
            end
         end
         S_ACCESS: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d = '0;
               if (!wr_q) buf_d[k_q*SRAM_DW +: SRAM_DW] = sram_readdata;
               if (nxt_found) begin
                  k_d = nxt_k;
               end else if (wr_q) begin
                  state_d = S_IDLE;
               end else begin
                  // Publish only complete words so avm_readdata holds between reads.
                  state_d = S_RESP;
                  rdata_d = buf_d;
               end
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset abandons any access in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         base_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         buf_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         base_q  <= base_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         buf_q   <= buf_d;
         rdata_q <= rdata_d;
      end
   end

   assign avm_waitrequest   = (state_q != S_IDLE);
   assign avm_readdatavalid = (state_q == S_RESP);
   assign avm_readdata      = rdata_q;

   // SRAM pins decode straight from state so reset parks them without waiting for a clock.
   always_comb begin
      sram_ce_n      = 1'b1;
      sram_oe_n      = 1'b1;
      sram_we_n      = 1'b1;
      sram_be_n      = '1;
      sram_addr      = '0;
      sram_writedata = '0;
      if (state_q == S_ACCESS) begin
         sram_ce_n = 1'b0;
         sram_addr = base_q + SRAM_AW'(k_q);
         if (wr_q) begin
            sram_we_n      = 1'b0;
            sram_be_n      = ~be_q[k_q*L +: L];
            sram_writedata = wdata_q[k_q*SRAM_DW +: SRAM_DW];
         end else begin
            sram_oe_n = 1'b0;
            sram_be_n = '0;
         end
      end
   end

endmodule

// File: tb/tb_avm_sram_wide_controller.sv
// tb/tb_avm_sram_wide_controller.sv - directed scoreboard bench for avm_sram_wide_controller
module tb_avm_sram_wide_controller;

   // {waitrequest, readdatavalid, ce_n, oe_n, we_n, be_n[1:0]}
   localparam logic [6:0] CTL_IDLE = 7'b0011111;
   localparam logic [6:0] CTL_WR   = 7'b1001000;
   localparam logic [6:0] CTL_WR_H = 7'b1001001;
   localparam logic [6:0] CTL_RD   = 7'b1000100;
   localparam logic [6:0] CTL_RESP = 7'b1111111;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;

   logic [19:0] avm_address;
   logic [3:0]  avm_byteenable;
   logic        avm_read, avm_write;
   logic [31:0] avm_writedata;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        avm_readdatavalid;
   logic [17:0] sram_addr;
   logic [15:0] sram_writedata, sram_readdata;
   logic        sram_ce_n, sram_oe_n, sram_we_n;
   logic [1:0]  sram_be_n;

   logic [19:0] b_address;
   logic [3:0]  b_byteenable;
   logic        b_read, b_write;
   logic [31:0] b_writedata;
   logic        b_waitrequest;
   logic [31:0] b_readdata;
   logic        b_readdatavalid;
   logic [17:0] b_sram_addr;
   logic [15:0] b_sram_writedata, b_sram_readdata;
   logic        b_sram_ce_n, b_sram_oe_n, b_sram_we_n;
   logic [1:0]  b_sram_be_n;

   avm_sram_wide_controller dut0 (
      .clk(clk), .reset_n(reset_n),
      .avm_address(avm_address), .avm_byteenable(avm_byteenable),
      .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
      .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
      .avm_readdatavalid(avm_readdatavalid),
      .sram_addr(sram_addr), .sram_writedata(sram_writedata), .sram_readdata(sram_readdata),
      .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
   );

   avm_sram_wide_controller #(.WAIT_CYCLES(2)) dut2 (
      .clk(clk), .reset_n(reset_n),
      .avm_address(b_address), .avm_byteenable(b_byteenable),
      .avm_read(b_read), .avm_write(b_write), .avm_writedata(b_writedata),
      .avm_waitrequest(b_waitrequest), .avm_readdata(b_readdata),
      .avm_readdatavalid(b_readdatavalid),
      .sram_addr(b_sram_addr), .sram_writedata(b_sram_writedata), .sram_readdata(b_sram_readdata),
      .sram_ce_n(b_sram_ce_n), .sram_oe_n(b_sram_oe_n), .sram_we_n(b_sram_we_n), .sram_be_n(b_sram_be_n)
   );

   // Async SRAM models, 256 words each, byte-lane writes.
   logic [15:0] mem0 [0:255];
   logic [15:0] mem2 [0:255];

   assign sram_readdata   = (!sram_ce_n && !sram_oe_n) ? mem0[sram_addr[7:0]] : 16'h0000;
   assign b_sram_readdata = (!b_sram_ce_n && !b_sram_oe_n) ? mem2[b_sram_addr[7:0]] : 16'h0000;

   always @(posedge clk) begin
      if (!sram_ce_n && !sram_we_n) begin
         if (!sram_be_n[0]) mem0[sram_addr[7:0]][7:0]  <= sram_writedata[7:0];
         if (!sram_be_n[1]) mem0[sram_addr[7:0]][15:8] <= sram_writedata[15:8];
      end
      if (!b_sram_ce_n && !b_sram_we_n) begin
         if (!b_sram_be_n[0]) mem2[b_sram_addr[7:0]][7:0]  <= b_sram_writedata[7:0];
         if (!b_sram_be_n[1]) mem2[b_sram_addr[7:0]][15:8] <= b_sram_writedata[15:8];
      end
   end

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every read data strobe must match the oldest expected read.
   always @(negedge clk) begin
      if (avm_readdatavalid) begin
         check("rdv_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) check("sb_readdata", avm_readdata, exp_q.pop_front());
      end
   end

   logic [6:0]  t_ctl [0:15];
   logic [17:0] t_addr[0:15];
   logic [15:0] t_wd  [0:15];
   logic [31:0] t_rd  [0:15];
   logic [6:0]  u_ctl [0:15];
   logic [17:0] u_addr[0:15];
   logic [31:0] u_rd  [0:15];

   task automatic trace(input int n);
      for (int j = 1; j <= n; j++) begin
         @(negedge clk);
         t_ctl[j]  = {avm_waitrequest, avm_readdatavalid, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n};
         t_addr[j] = sram_addr;
         t_wd[j]   = sram_writedata;
         t_rd[j]   = avm_readdata;
         u_ctl[j]  = {b_waitrequest, b_readdatavalid, b_sram_ce_n, b_sram_oe_n, b_sram_we_n, b_sram_be_n};
         u_addr[j] = b_sram_addr;
         u_rd[j]   = b_readdata;
      end
   endtask

   // Present one command for one accepting clock edge; first negedge afterwards is cycle N+1.
   task automatic issue(input bit sel2, input logic rd, input logic wr, input logic [19:0] a,
                        input logic [3:0] be, input logic [31:0] d);
      int guard;
      guard = 0;
      @(negedge clk);
      while ((sel2 ? b_waitrequest : avm_waitrequest) && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("issue_ready", 32'(guard < 50), 32'd1);
      if (sel2) begin
         b_address = a; b_byteenable = be; b_writedata = d; b_read = rd; b_write = wr;
      end else begin
         avm_address = a; avm_byteenable = be; avm_writedata = d; avm_read = rd; avm_write = wr;
      end
      @(posedge clk);
      #1;
      avm_read = 1'b0; avm_write = 1'b0;
      b_read = 1'b0; b_write = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      avm_address = '0; avm_byteenable = '0; avm_read = 1'b0; avm_write = 1'b0; avm_writedata = '0;
      b_address = '0; b_byteenable = '0; b_read = 1'b0; b_write = 1'b0; b_writedata = '0;
      repeat (3) @(negedge clk);
      check("rst_ctl", 32'({avm_waitrequest, avm_readdatavalid, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n}), 32'(CTL_IDLE));
      check("rst_addr", 32'(sram_addr), 32'd0);
      check("rst_wdata", 32'(sram_writedata), 32'd0);
      check("rst_rdata", avm_readdata, 32'd0);
      reset_n = 1'b1;

      // Full-width write then read at 0x4
      issue(0, 0, 1, 20'h4, 4'hF, 32'hBBBBAAAA);
      trace(3);
      check("wr4_ctl1", 32'(t_ctl[1]), 32'(CTL_WR));
      check("wr4_addr1", 32'(t_addr[1]), 32'h2);
      check("wr4_wd1", 32'(t_wd[1]), 32'hAAAA);
      check("wr4_ctl2", 32'(t_ctl[2]), 32'(CTL_WR));
      check("wr4_addr2", 32'(t_addr[2]), 32'h3);
      check("wr4_wd2", 32'(t_wd[2]), 32'hBBBB);
      check("wr4_ctl3", 32'(t_ctl[3]), 32'(CTL_IDLE));
      check("wr4_idle_addr", 32'(t_addr[3]), 32'd0);
      check("wr4_idle_wd", 32'(t_wd[3]), 32'd0);

      exp_q.push_back(32'hBBBBAAAA);
      issue(0, 1, 0, 20'h4, 4'h0, 32'h0);
      trace(4);
      check("rd4_ctl1", 32'(t_ctl[1]), 32'(CTL_RD));
      check("rd4_addr1", 32'(t_addr[1]), 32'h2);
      check("rd4_ctl2", 32'(t_ctl[2]), 32'(CTL_RD));
      check("rd4_addr2", 32'(t_addr[2]), 32'h3);
      check("rd4_ctl3", 32'(t_ctl[3]), 32'(CTL_RESP));
      check("rd4_ctl4", 32'(t_ctl[4]), 32'(CTL_IDLE));
      check("rd4_hold", t_rd[4], 32'hBBBBAAAA);

      // Low-half partial write over DEADBEEF at 0x20
      issue(0, 0, 1, 20'h20, 4'hF, 32'hDEADBEEF);
      trace(3);
      issue(0, 0, 1, 20'h20, 4'h3, 32'h0000FFFF);
      trace(2);
      check("wr20_ctl1", 32'(t_ctl[1]), 32'(CTL_WR));
      check("wr20_addr1", 32'(t_addr[1]), 32'h10);
      check("wr20_wd1", 32'(t_wd[1]), 32'hFFFF);
      check("wr20_ctl2", 32'(t_ctl[2]), 32'(CTL_IDLE));
      exp_q.push_back(32'hDEADFFFF);
      issue(0, 1, 0, 20'h20, 4'h0, 32'h0);
      trace(4);

      // Top byte only at 0x10: sub-word 0 skipped
      issue(0, 0, 1, 20'h10, 4'hF, 32'h12345678);
      trace(3);
      issue(0, 0, 1, 20'h10, 4'h8, 32'hFF345678);
      trace(2);
      check("wr10_ctl1", 32'(t_ctl[1]), 32'(CTL_WR_H));
      check("wr10_addr1", 32'(t_addr[1]), 32'h9);
      check("wr10_wd1", 32'(t_wd[1]), 32'hFF34);
      check("wr10_ctl2", 32'(t_ctl[2]), 32'(CTL_IDLE));
      exp_q.push_back(32'hFF345678);
      issue(0, 1, 0, 20'h10, 4'h0, 32'h0);
      trace(4);

      // All-zero byteenable write: accepted, no SRAM activity
      issue(0, 0, 1, 20'h30, 4'h0, 32'h55555555);
      trace(2);
      check("wr0_ctl1", 32'(t_ctl[1]), 32'(CTL_IDLE));
      check("wr0_ctl2", 32'(t_ctl[2]), 32'(CTL_IDLE));

      // Read and write together: the write wins
      issue(0, 1, 1, 20'h8, 4'hF, 32'h11112222);
      trace(3);
      check("rw_ctl1", 32'(t_ctl[1]), 32'(CTL_WR));
      check("rw_addr2", 32'(t_addr[2]), 32'h5);
      check("rw_ctl3", 32'(t_ctl[3]), 32'(CTL_IDLE));
      exp_q.push_back(32'h11112222);
      issue(0, 1, 0, 20'h8, 4'h0, 32'h0);
      trace(4);

      // Top of the byte space wraps the SRAM word address
      issue(0, 0, 1, 20'hFFFFC, 4'hF, 32'hCAFEF00D);
      trace(3);
      check("wrap_addr1", 32'(t_addr[1]), 32'h3FFFE);
      check("wrap_addr2", 32'(t_addr[2]), 32'h3FFFF);
      exp_q.push_back(32'hCAFEF00D);
      issue(0, 1, 0, 20'hFFFFC, 4'h0, 32'h0);
      trace(4);
      check("wrap_rd_ctl3", 32'(t_ctl[3]), 32'(CTL_RESP));

      // Three cycles per sub-word on the WAIT_CYCLES=2 instance
      issue(1, 0, 1, 20'h4, 4'hF, 32'h24681357);
      trace(7);
      check("w2_wr_ctl1", 32'(u_ctl[1]), 32'(CTL_WR));
      check("w2_wr_ctl6", 32'(u_ctl[6]), 32'(CTL_WR));
      check("w2_wr_addr4", 32'(u_addr[4]), 32'h3);
      check("w2_wr_ctl7", 32'(u_ctl[7]), 32'(CTL_IDLE));
      issue(1, 1, 0, 20'h4, 4'h0, 32'h0);
      trace(8);
      check("w2_rd_ctl1", 32'(u_ctl[1]), 32'(CTL_RD));
      check("w2_rd_addr3", 32'(u_addr[3]), 32'h2);
      check("w2_rd_addr4", 32'(u_addr[4]), 32'h3);
      check("w2_rd_ctl6", 32'(u_ctl[6]), 32'(CTL_RD));
      check("w2_rd_ctl7", 32'(u_ctl[7]), 32'(CTL_RESP));
      check("w2_rd_data7", u_rd[7], 32'h24681357);
      check("w2_rd_ctl8", 32'(u_ctl[8]), 32'(CTL_IDLE));

      // Reset in the middle of read sub-word 1: no response, pins park immediately
      issue(0, 1, 0, 20'h4, 4'h0, 32'h0);
      @(negedge clk);
      @(negedge clk);
      check("rst_mid_pre", 32'({sram_ce_n, sram_oe_n}), 32'd0);
      reset_n = 1'b0;
      #1;
      check("rst_mid_ctl", 32'({avm_waitrequest, avm_readdatavalid, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n}), 32'(CTL_IDLE));
      check("rst_mid_addr", 32'(sram_addr), 32'd0);
      check("rst_mid_rdata", avm_readdata, 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      trace(3);
      check("rst_post_ctl1", 32'(t_ctl[1]), 32'(CTL_IDLE));
      check("rst_post_ctl3", 32'(t_ctl[3]), 32'(CTL_IDLE));
      exp_q.push_back(32'hBBBBAAAA);
      issue(0, 1, 0, 20'h4, 4'h0, 32'h0);
      trace(4);
      check("rst_rd_ctl3", 32'(t_ctl[3]), 32'(CTL_RESP));

      repeat (3) @(negedge clk);
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
